// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory controller.
package dm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait,
    StErr
  } dm_state_e;

  localparam int unsigned CntW     = 2;
  localparam int unsigned BusAddrW = 16;
  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 16;

  // The counter holds cycles remaining after the accepting edge, so a latency of 4 loads 3.
  function automatic logic [CntW-1:0] lat_to_cnt(input int unsigned lat);
    return CntW'(lat - 1);
  endfunction

endpackage

// File: rtl/dm_if.sv
// Request/busy/done bus between the control unit and the data-memory controller.
interface dm_if #(
  parameter int unsigned DATA_W = dm_pkg::DefDataW
) ();

  logic [dm_pkg::BusAddrW-1:0] ADDR;
  logic [DATA_W-1:0]           DIN;
  logic                        MEMRD;
  logic                        MEMWR;
  logic [DATA_W-1:0]           DOUT;
  logic                        BUSY;
  logic                        DONE;
  logic                        ERR;

  modport master (
    output ADDR, DIN, MEMRD, MEMWR,
    input  DOUT, BUSY, DONE, ERR
  );

  modport slave (
    input  ADDR, DIN, MEMRD, MEMWR,
    output DOUT, BUSY, DONE, ERR
  );

endinterface

// File: rtl/dm_sram.sv
// Single-port synchronous word array with a registered read port; contents are not reset.
module dm_sram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_ctrl.sv
// Multi-cycle data-memory controller: accepts one read or write in idle, completes it after a
// fixed latency with a one-cycle DONE pulse, and flags conflicting or out-of-range requests.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input logic  clk,
  input logic  rst_n,
  dm_if.slave  bus_io
);

  localparam logic [CntW-1:0] RdCnt = lat_to_cnt(RD_LAT);
  localparam logic [CntW-1:0] WrCnt = lat_to_cnt(WR_LAT);

  dm_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              addr_oob;
  logic              last_cycle;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;

  // Any set bit above the implemented width is an error, never an alias.
  assign addr_oob   = (bus_io.ADDR >> ADDR_W) != '0;
  assign last_cycle = (cnt_q == '0);

  // In idle the array already reads the incoming address, so a one-cycle read still has
  // registered data ready at its completion edge.
  assign sram_addr = (state_q == StIdle) ? bus_io.ADDR[ADDR_W-1:0] : addr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sram_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.MEMRD || bus_io.MEMWR) begin
          if ((bus_io.MEMRD && bus_io.MEMWR) || addr_oob) begin
            state_d = StErr;
          end else if (bus_io.MEMRD) begin
            state_d = StRdWait;
            cnt_d   = RdCnt;
            addr_d  = bus_io.ADDR[ADDR_W-1:0];
          end else begin
            state_d = StWrWait;
            cnt_d   = WrCnt;
            addr_d  = bus_io.ADDR[ADDR_W-1:0];
            wdata_d = bus_io.DIN;
          end
        end
      end
      StRdWait: begin
        if (last_cycle) begin
          state_d = StIdle;
          done_d  = 1'b1;
          dout_d  = sram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWrWait: begin
        if (last_cycle) begin
          state_d = StIdle;
          done_d  = 1'b1;
          sram_we = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StErr: begin
        state_d = StIdle;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  dm_sram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  assign bus_io.DOUT = dout_q;
  assign bus_io.BUSY = (state_q != StIdle);
  assign bus_io.DONE = done_q;
  assign bus_io.ERR  = err_q;

endmodule
